// File: rtl/conv2_pkg.sv
// conv2_pkg: shared constants and types for the conv2 sequencing controller.
// Holds the default layer geometry, the values derived from it, the FSM state
// type and a counter-width helper used by conv2_loop_ctr and conv2_sched.
package conv2_pkg;

  localparam int IMG_DIM = 27;
  localparam int K       = 5;
  localparam int PAD     = 2;
  localparam int IN_CH   = 96;
  localparam int IC_PAR  = 8;
  localparam int OUT_CH  = 256;
  localparam int OC_PAR  = 16;

  localparam int ICB           = IN_CH / IC_PAR;
  localparam int OCG           = OUT_CH / OC_PAR;
  localparam int BEATS_PER_PIX = K * K * ICB;
  localparam int TOTAL_PIX     = OCG * IMG_DIM * IMG_DIM;

  localparam int ACT_AW = $clog2(IMG_DIM * IMG_DIM * ICB);
  localparam int WGT_AW = $clog2(OCG * K * K * ICB);
  localparam int OUT_AW = $clog2(TOTAL_PIX);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2_loop_ctr.sv
// conv2_loop_ctr: nested ocg/row/col/ky/kx/icb counter (outermost first).
// Latency: *_d is the combinational next value, *_q updates on the next edge.
// Backpressure: holds while adv=0; clr zeroes every level and wins over adv.
// Ports: clk, rst (sync, active high), clr, adv; *_q current indices,
//        *_d next indices, last = every level at its final value.
module conv2_loop_ctr
  import conv2_pkg::cw;
#(
  parameter int N_OCG = 16,
  parameter int N_DIM = 27,
  parameter int N_K   = 5,
  parameter int N_ICB = 12,
  parameter int OW    = cw(N_OCG),
  parameter int PW    = cw(N_DIM),
  parameter int KW    = cw(N_K),
  parameter int IW    = cw(N_ICB)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [OW-1:0] ocg_q,
  output logic [PW-1:0] row_q,
  output logic [PW-1:0] col_q,
  output logic [KW-1:0] ky_q,
  output logic [KW-1:0] kx_q,
  output logic [IW-1:0] icb_q,
  output logic [OW-1:0] ocg_d,
  output logic [PW-1:0] row_d,
  output logic [PW-1:0] col_d,
  output logic [KW-1:0] ky_d,
  output logic [KW-1:0] kx_d,
  output logic [IW-1:0] icb_d,
  output logic          last
);

  logic ocg_w, row_w, col_w, ky_w, kx_w, icb_w;

  always_comb begin
    ocg_w = (ocg_q == OW'(N_OCG - 1));
    row_w = (row_q == PW'(N_DIM - 1));
    col_w = (col_q == PW'(N_DIM - 1));
    ky_w  = (ky_q  == KW'(N_K - 1));
    kx_w  = (kx_q  == KW'(N_K - 1));
    icb_w = (icb_q == IW'(N_ICB - 1));
    last  = ocg_w && row_w && col_w && ky_w && kx_w && icb_w;

    ocg_d = ocg_q;
    row_d = row_q;
    col_d = col_q;
    ky_d  = ky_q;
    kx_d  = kx_q;
    icb_d = icb_q;

    if (clr) begin
      ocg_d = '0;
      row_d = '0;
      col_d = '0;
      ky_d  = '0;
      kx_d  = '0;
      icb_d = '0;
    end else if (adv) begin
      // Each level steps only when every level inside it wraps.
      icb_d = icb_w ? '0 : icb_q + IW'(1);
      if (icb_w) begin
        kx_d = kx_w ? '0 : kx_q + KW'(1);
        if (kx_w) begin
          ky_d = ky_w ? '0 : ky_q + KW'(1);
          if (ky_w) begin
            col_d = col_w ? '0 : col_q + PW'(1);
            if (col_w) begin
              row_d = row_w ? '0 : row_q + PW'(1);
              if (row_w) begin
                ocg_d = ocg_w ? '0 : ocg_q + OW'(1);
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ocg_q <= '0;
      row_q <= '0;
      col_q <= '0;
      ky_q  <= '0;
      kx_q  <= '0;
      icb_q <= '0;
    end else begin
      ocg_q <= ocg_d;
      row_q <= row_d;
      col_q <= col_d;
      ky_q  <= ky_d;
      kx_q  <= kx_d;
      icb_q <= icb_d;
    end
  end

endmodule

// File: rtl/conv2_sched.sv
// conv2_sched: issues conv2 operand beats to one MAC engine and tracks write-backs.
// Latency: first beat the cycle after start; done one cycle after the last pix_wr.
// Backpressure: beat fields are registered and held while beat_valid && !beat_ready.
// Ports: start/busy/done to the layer sequencer; beat_valid/beat_ready with
//        act_addr, wgt_addr, pad_zero, acc_first, acc_last, out_addr to the MAC
//        engine; pix_wr back from the MAC engine, one pulse per finished pixel.
module conv2_sched
  import conv2_pkg::state_e;
  import conv2_pkg::IDLE;
  import conv2_pkg::ISSUE;
  import conv2_pkg::DRAIN;
  import conv2_pkg::DONE;
  import conv2_pkg::cw;
#(
  parameter int IMG_DIM = conv2_pkg::IMG_DIM,
  parameter int K       = conv2_pkg::K,
  parameter int PAD     = conv2_pkg::PAD,
  parameter int IN_CH   = conv2_pkg::IN_CH,
  parameter int IC_PAR  = conv2_pkg::IC_PAR,
  parameter int OUT_CH  = conv2_pkg::OUT_CH,
  parameter int OC_PAR  = conv2_pkg::OC_PAR,
  parameter int ACT_AW  = $clog2(IMG_DIM * IMG_DIM * (IN_CH / IC_PAR)),
  parameter int WGT_AW  = $clog2((OUT_CH / OC_PAR) * K * K * (IN_CH / IC_PAR)),
  parameter int OUT_AW  = $clog2((OUT_CH / OC_PAR) * IMG_DIM * IMG_DIM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              beat_valid,
  input  logic              beat_ready,
  output logic [ACT_AW-1:0] act_addr,
  output logic [WGT_AW-1:0] wgt_addr,
  output logic              pad_zero,
  output logic              acc_first,
  output logic              acc_last,
  output logic [OUT_AW-1:0] out_addr,
  input  logic              pix_wr
);

  localparam int ICB       = IN_CH / IC_PAR;
  localparam int OCG       = OUT_CH / OC_PAR;
  localparam int TOTAL_PIX = OCG * IMG_DIM * IMG_DIM;
  localparam int OW        = cw(OCG);
  localparam int PW        = cw(IMG_DIM);
  localparam int KW        = cw(K);
  localparam int IW        = cw(ICB);
  localparam int WW        = $clog2(TOTAL_PIX + 1);

  state_e            state_q, state_d;
  logic [WW-1:0]     wr_cnt_q, wr_cnt_d;
  logic [ACT_AW-1:0] act_addr_q, act_addr_d;
  logic [WGT_AW-1:0] wgt_addr_q, wgt_addr_d;
  logic [OUT_AW-1:0] out_addr_q, out_addr_d;
  logic              pad_zero_q, pad_zero_d;
  logic              acc_first_q, acc_first_d;
  logic              acc_last_q, acc_last_d;

  logic start_acc, fire, ctr_last;
  logic [OW-1:0] ocg_c, ocg_n;
  logic [PW-1:0] row_c, row_n, col_c, col_n;
  logic [KW-1:0] ky_c, ky_n, kx_c, kx_n;
  logic [IW-1:0] icb_c, icb_n;
  int in_row, in_col, act_c, wgt_c, out_c;

  // The counter sits on the beat currently presented; its next value is what
  // the beat registers load, so the fields stay aligned with the indices.
  conv2_loop_ctr #(
    .N_OCG(OCG),
    .N_DIM(IMG_DIM),
    .N_K  (K),
    .N_ICB(ICB),
    .OW   (OW),
    .PW   (PW),
    .KW   (KW),
    .IW   (IW)
  ) u_loop_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_acc),
    .adv  (fire),
    .ocg_q(ocg_c),
    .row_q(row_c),
    .col_q(col_c),
    .ky_q (ky_c),
    .kx_q (kx_c),
    .icb_q(icb_c),
    .ocg_d(ocg_n),
    .row_d(row_n),
    .col_d(col_n),
    .ky_d (ky_n),
    .kx_d (kx_n),
    .icb_d(icb_n),
    .last (ctr_last)
  );

  always_comb begin
    start_acc = (state_q == IDLE) && start;
    fire      = (state_q == ISSUE) && beat_ready;

    wr_cnt_d = wr_cnt_q;
    if (start_acc) begin
      wr_cnt_d = '0;
    end else if ((state_q != IDLE) && pix_wr && (wr_cnt_q != WW'(TOTAL_PIX))) begin
      wr_cnt_d = wr_cnt_q + WW'(1);
    end

    // Completion looks at the updated count so done follows the final pix_wr
    // by exactly one cycle, even when it lands on the last accepted beat.
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (fire && ctr_last) state_d = (wr_cnt_d == WW'(TOTAL_PIX)) ? DONE : DRAIN;
      DRAIN:   if (wr_cnt_d == WW'(TOTAL_PIX)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Beat fields for the next counter position (signed window arithmetic).
    in_row = int'(row_n) + int'(ky_n) - PAD;
    in_col = int'(col_n) + int'(kx_n) - PAD;
    act_c  = (in_row * IMG_DIM + in_col) * ICB + int'(icb_n);
    wgt_c  = ((int'(ocg_n) * K + int'(ky_n)) * K + int'(kx_n)) * ICB + int'(icb_n);
    out_c  = int'(ocg_n) * IMG_DIM * IMG_DIM + int'(row_n) * IMG_DIM + int'(col_n);

    act_addr_d  = act_addr_q;
    wgt_addr_d  = wgt_addr_q;
    out_addr_d  = out_addr_q;
    pad_zero_d  = pad_zero_q;
    acc_first_d = acc_first_q;
    acc_last_d  = acc_last_q;

    if (start_acc || (fire && !ctr_last)) begin
      pad_zero_d  = (in_row < 0) || (in_row > IMG_DIM - 1) ||
                    (in_col < 0) || (in_col > IMG_DIM - 1);
      act_addr_d  = pad_zero_d ? '0 : ACT_AW'(act_c);
      wgt_addr_d  = WGT_AW'(wgt_c);
      out_addr_d  = OUT_AW'(out_c);
      acc_first_d = (ky_n == '0) && (kx_n == '0) && (icb_n == '0);
      acc_last_d  = (ky_n == KW'(K - 1)) && (kx_n == KW'(K - 1)) && (icb_n == IW'(ICB - 1));
    end else if (fire && ctr_last) begin
      // Nothing left to present once the final beat is taken.
      act_addr_d  = '0;
      wgt_addr_d  = '0;
      out_addr_d  = '0;
      pad_zero_d  = 1'b0;
      acc_first_d = 1'b0;
      acc_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_cnt_q    <= '0;
      act_addr_q  <= '0;
      wgt_addr_q  <= '0;
      out_addr_q  <= '0;
      pad_zero_q  <= 1'b0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      act_addr_q  <= act_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      out_addr_q  <= out_addr_d;
      pad_zero_q  <= pad_zero_d;
      acc_first_q <= acc_first_d;
      acc_last_q  <= acc_last_d;
    end
  end

  assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign beat_valid = (state_q == ISSUE);
  assign act_addr   = act_addr_q;
  assign wgt_addr   = wgt_addr_q;
  assign out_addr   = out_addr_q;
  assign pad_zero   = pad_zero_q;
  assign acc_first  = acc_first_q;
  assign acc_last   = acc_last_q;

endmodule

// File: tb/tb_conv2_sched.sv
// tb_conv2_sched: randomized self-checking bench for conv2_sched, small config.
// Beat expectations come from a loop-nest model built from the address formulas.
module tb_conv2_sched;

  localparam int IMG = 4;
  localparam int KK  = 3;
  localparam int PD  = 1;
  localparam int NB  = 2 * IMG * IMG * KK * KK;   // 288 beats
  localparam int NPIX = 2 * IMG * IMG;            // 32 pixels

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       beat_ready = 1'b0;
  logic       pix_wr = 1'b0;
  logic       busy, done, beat_valid, pad_zero, acc_first, acc_last;
  logic [3:0] act_addr;
  logic [4:0] wgt_addr;
  logic [4:0] out_addr;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] m_act [NB];
  logic [4:0] m_wgt [NB];
  logic [4:0] m_out [NB];
  logic       m_pad [NB];
  logic       m_first [NB];
  logic       m_last [NB];

  always #5 clk = ~clk;

  conv2_sched #(
    .IMG_DIM(IMG), .K(KK), .PAD(PD), .IN_CH(8), .IC_PAR(8), .OUT_CH(32), .OC_PAR(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .beat_valid(beat_valid), .beat_ready(beat_ready),
    .act_addr(act_addr), .wgt_addr(wgt_addr), .pad_zero(pad_zero),
    .acc_first(acc_first), .acc_last(acc_last), .out_addr(out_addr), .pix_wr(pix_wr)
  );

  task automatic build_model();
    int n = 0;
    for (int ocg = 0; ocg < 2; ocg++)
      for (int r = 0; r < IMG; r++)
        for (int c = 0; c < IMG; c++)
          for (int ky = 0; ky < KK; ky++)
            for (int kx = 0; kx < KK; kx++) begin
              int ir = r + ky - PD;
              int ic = c + kx - PD;
              bit pz = (ir < 0) || (ir >= IMG) || (ic < 0) || (ic >= IMG);
              m_pad[n]   = pz;
              m_act[n]   = pz ? 4'd0 : 4'(ir * IMG + ic);
              m_wgt[n]   = 5'((ocg * KK + ky) * KK + kx);
              m_out[n]   = 5'(ocg * IMG * IMG + r * IMG + c);
              m_first[n] = (ky == 0) && (kx == 0);
              m_last[n]  = (ky == KK - 1) && (kx == KK - 1);
              n++;
            end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    logic [20:0] obs;
    obs = {busy, done, beat_valid, act_addr, wgt_addr, out_addr, pad_zero, acc_first, acc_last};
    n_cmp++;
    if (obs !== 21'd0) begin
      n_err++;
      $display("FAIL %s outputs got %h expected 0", tag, obs);
    end
  endtask

  // One full pass: ready_pct sets beat_ready density, disturb re-pulses start
  // while busy, withhold holds back the final pix_wr, rst_beat >= 0 resets at
  // that beat index. pix_wr returns 3 cycles after each acc_last beat.
  task automatic run_pass(input int ready_pct, input bit disturb, input bit withhold,
                          input int rst_beat);
    int idx = 0, cyc = 0, last_cyc = -1, done_cyc = -1, n_done = 0, n_al = 0;
    int held_cyc = -1, rel_cyc = -1;
    int pix_due[$];
    bit finished = 0, fire;
    logic [16:0] obs, expv;

    start = 1'b1; beat_ready = 1'b0; pix_wr = 1'b0;
    step();
    start = 1'b0;
    n_cmp++;
    if ({busy, beat_valid} !== 2'b11) begin
      n_err++;
      $display("FAIL start_latency busy/valid got %b expected 11", {busy, beat_valid});
    end

    while (!finished && cyc < 4000) begin
      if (done === 1'b1) begin
        n_done++; done_cyc = cyc;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL busy_at_done got %b expected 0", busy); end
      end else if (done_cyc >= 0 && cyc == done_cyc + 1) begin
        n_cmp++;
        if ({busy, beat_valid} !== 2'b00) begin
          n_err++; $display("FAIL back_to_idle busy/valid got %b expected 00", {busy, beat_valid});
        end
        finished = 1;
      end

      if (idx < NB) begin
        obs  = {act_addr, wgt_addr, out_addr, pad_zero, acc_first, acc_last};
        expv = {m_act[idx], m_wgt[idx], m_out[idx], m_pad[idx], m_first[idx], m_last[idx]};
        n_cmp++;
        if (beat_valid !== 1'b1 || obs !== expv) begin
          n_err++;
          $display("FAIL beat[%0d] valid=%b fields got %h expected %h", idx, beat_valid, obs, expv);
        end
        if (idx == 0) begin
          n_cmp++;
          if ({pad_zero, acc_first, wgt_addr, out_addr} !== 12'b11_00000_00000) begin
            n_err++; $display("FAIL first_beat got %b expected 110000000000",
                              {pad_zero, acc_first, wgt_addr, out_addr});
          end
        end
        if (idx == 49) begin
          n_cmp++;
          if ({act_addr, pad_zero} !== {4'd5, 1'b0}) begin
            n_err++; $display("FAIL interior_beat act/pad got %h/%b expected 5/0", act_addr, pad_zero);
          end
        end
      end else if (!finished && done !== 1'b1) begin
        n_cmp++;
        if ({busy, beat_valid} !== 2'b10) begin
          n_err++; $display("FAIL drain busy/valid got %b expected 10", {busy, beat_valid});
        end
      end

      if (held_cyc >= 0 && rel_cyc < 0 && cyc > held_cyc) begin
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL withheld_done got %b expected 0", done); end
      end

      if (rst_beat >= 0 && idx == rst_beat) begin
        rst = 1'b1; beat_ready = 1'b1; pix_wr = 1'b0;
        step();
        rst = 1'b0; beat_ready = 1'b0;
        check_idle_outputs("mid_reset");
        for (int i = 0; i < 6; i++) begin
          step();
          n_cmp++;
          if ({busy, done, beat_valid} !== 3'b000) begin
            n_err++; $display("FAIL after_reset busy/done/valid got %b expected 000",
                              {busy, done, beat_valid});
          end
        end
        return;
      end

      beat_ready = ($urandom_range(0, 99) < ready_pct);
      fire = (beat_valid === 1'b1) && beat_ready;
      pix_wr = 1'b0;
      if (pix_due.size() > 0 && pix_due[0] == cyc) begin
        void'(pix_due.pop_front());
        if (withhold && idx == NB && pix_due.size() == 0) held_cyc = cyc;
        else pix_wr = 1'b1;
      end
      if (held_cyc >= 0 && cyc == held_cyc + 20) begin
        pix_wr = 1'b1; rel_cyc = cyc;
      end
      start = disturb && (busy === 1'b1) && ($urandom_range(0, 9) == 0);
      if (fire) begin
        if (m_last[idx]) begin pix_due.push_back(cyc + 3); n_al++; end
        if (idx == NB - 1) last_cyc = cyc;
        idx++;
      end
      step();
      cyc++;
    end
    start = 1'b0; pix_wr = 1'b0; beat_ready = 1'b0;

    n_cmp++;
    if (!finished) begin n_err++; $display("FAIL pass_timeout beats=%0d expected %0d", idx, NB); end
    n_cmp++;
    if (n_done != 1) begin n_err++; $display("FAIL done_count got %0d expected 1", n_done); end
    n_cmp++;
    if (n_al != NPIX) begin n_err++; $display("FAIL acc_last_count got %0d expected %0d", n_al, NPIX); end
    n_cmp++;
    if (withhold) begin
      if (done_cyc != rel_cyc + 1) begin
        n_err++; $display("FAIL done_after_release got cyc %0d expected %0d", done_cyc, rel_cyc + 1);
      end
    end else if (done_cyc != last_cyc + 4) begin
      n_err++; $display("FAIL done_timing got cyc %0d expected %0d", done_cyc, last_cyc + 4);
    end
    if (ready_pct == 100) begin
      n_cmp++;
      if (last_cyc != NB - 1) begin
        n_err++; $display("FAIL no_bubble last beat cyc %0d expected %0d", last_cyc, NB - 1);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_idle_outputs("reset_state");
    step();
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_no_stall();
    run_pass(100, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_pass(50, 1'b0, 1'b0, -1);
  endtask

  task automatic test_ignored_inputs();
    for (int i = 0; i < 4; i++) begin
      pix_wr = 1'b1;
      step();
      pix_wr = 1'b0;
      n_cmp++;
      if ({busy, beat_valid, done} !== 3'b000) begin
        n_err++; $display("FAIL idle_pix_wr busy/valid/done got %b expected 000", {busy, beat_valid, done});
      end
    end
    run_pass(70, 1'b1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_pass();
    run_pass(100, 1'b0, 1'b0, 99);
    run_pass(100, 1'b0, 1'b0, -1);
  endtask

  task automatic test_withhold();
    run_pass(60, 1'b0, 1'b1, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    build_model();
    test_reset();
    test_no_stall();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid_pass();
    test_withhold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
